// File: rtl/stats_collect_pkg.sv
// stats_collect_pkg
//   Shared definitions for the statistics collector: scan/emit FSM state
//   encodings, the width rule for the saturating accumulator add, and the
//   reduction of the configured counter-ID base into the tid width.
package stats_collect_pkg;

   typedef enum logic [0:0] {
      STATE_IDLE  = 1'b0,
      STATE_SWEEP = 1'b1
   } state_t;

   // One carry bit above the accumulator is enough to detect overflow,
   // because the increment is always narrower than the accumulator.
   function automatic int unsigned sat_sum_width(input int unsigned acc_width);
      return acc_width + 1;
   endfunction

   // Counter-ID base reduced mod 2^id_width; per-channel IDs are then
   // base + channel in id_width-bit arithmetic, which wraps naturally.
   function automatic int unsigned stat_id_base(input int unsigned base,
                                                input int unsigned id_width);
      if (id_width >= 32)
         return base;
      return base & ((32'd1 << id_width) - 32'd1);
   endfunction

endpackage

// File: rtl/stats_collect.sv
// stats_collect
//   Gathers per-cycle event increments from COUNT channels into saturating
//   local accumulators and serialises non-zero totals as (tdata, tid) beats
//   on an AXI-stream output. A periodic sweep drains every channel; a channel
//   whose accumulator reaches half scale is drained early while idle.
//
// Ports
//   clk                 clock
//   rst                 asynchronous active-high reset
//   stat_inc            per-channel increment, channel i at [i*INC_WIDTH +: INC_WIDTH]
//   stat_valid          per-channel qualifier for stat_inc (no back-pressure)
//   m_axis_stat_tdata   accumulated increment
//   m_axis_stat_tid     counter ID (STAT_ID_BASE + channel, wrapping)
//   m_axis_stat_tvalid  beat valid
//   m_axis_stat_tready  downstream ready
module stats_collect
   import stats_collect_pkg::*;
#(
   parameter int unsigned COUNT          = 8,
   parameter int unsigned INC_WIDTH      = 8,
   parameter int unsigned STAT_INC_WIDTH = 16,
   parameter int unsigned STAT_ID_WIDTH  = 8,
   parameter int unsigned STAT_ID_BASE   = 0,
   parameter int unsigned UPDATE_PERIOD  = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [COUNT*INC_WIDTH-1:0] stat_inc,
   input  logic [COUNT-1:0]           stat_valid,
   output logic [STAT_INC_WIDTH-1:0]  m_axis_stat_tdata,
   output logic [STAT_ID_WIDTH-1:0]   m_axis_stat_tid,
   output logic                       m_axis_stat_tvalid,
   input  logic                       m_axis_stat_tready
);

   localparam int unsigned PTR_W   = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam int unsigned SUM_W   = sat_sum_width(STAT_INC_WIDTH);
   localparam int unsigned TIMER_W = (UPDATE_PERIOD > 0) ? $clog2(UPDATE_PERIOD + 1) : 1;

   localparam logic [PTR_W-1:0]          PTR_LAST     = PTR_W'(COUNT - 1);
   localparam logic [TIMER_W-1:0]        TIMER_INIT   = TIMER_W'(UPDATE_PERIOD);
   localparam logic [TIMER_W-1:0]        TIMER_RELOAD =
      TIMER_W'((UPDATE_PERIOD == 0) ? 0 : UPDATE_PERIOD - 1);
   localparam logic [STAT_ID_WIDTH-1:0]  ID_BASE      =
      STAT_ID_WIDTH'(stat_id_base(STAT_ID_BASE, STAT_ID_WIDTH));
   localparam logic [STAT_INC_WIDTH-1:0] ACC_MAX      = '1;

   state_t                    state, state_next;
   logic [PTR_W-1:0]          ptr, ptr_next, ptr_inc;
   logic [TIMER_W-1:0]        timer;
   logic                      timer_expired;
   logic                      sweep_pending, pending_clr;
   logic                      slot_free, emit;

   logic [STAT_INC_WIDTH-1:0] acc      [COUNT];
   logic [STAT_INC_WIDTH-1:0] acc_next [COUNT];
   logic [STAT_INC_WIDTH-1:0] inc_ext  [COUNT];
   logic [SUM_W-1:0]          acc_sum  [COUNT];
   logic [STAT_INC_WIDTH-1:0] acc_cur;

   assign slot_free     = !m_axis_stat_tvalid || m_axis_stat_tready;
   assign timer_expired = (timer == '0);
   assign ptr_inc       = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);

   always_comb begin
      acc_cur = acc[ptr];
   end

   // Scan/emit FSM
   always_comb begin
      state_next  = state;
      ptr_next    = ptr;
      emit        = 1'b0;
      pending_clr = 1'b0;
      case (state)
         STATE_IDLE: begin
            ptr_next = ptr_inc;
            if (slot_free && acc_cur[STAT_INC_WIDTH-1])
               emit = 1'b1;
            if (sweep_pending) begin
               pending_clr = 1'b1;
               ptr_next    = '0;
               state_next  = STATE_SWEEP;
            end
         end
         STATE_SWEEP: begin
            // Empty channels are skipped; a non-empty one waits for the slot.
            if ((acc_cur == '0) || slot_free) begin
               emit     = (acc_cur != '0);
               ptr_next = ptr_inc;
               if (ptr == PTR_LAST)
                  state_next = STATE_IDLE;
            end
         end
         default: begin
            state_next = STATE_IDLE;
            ptr_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= STATE_IDLE;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   // Sweep timer; an expiry takes priority over the IDLE clear so that an
   // expiry during a sweep queues the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer         <= TIMER_INIT;
         sweep_pending <= 1'b0;
      end else begin
         if (timer_expired)
            timer <= TIMER_RELOAD;
         else
            timer <= timer - TIMER_W'(1);

         if (timer_expired)
            sweep_pending <= 1'b1;
         else if (pending_clr)
            sweep_pending <= 1'b0;
      end
   end

   // Accumulators: the emitted channel restarts from this cycle's increment,
   // so an increment arriving in the emission cycle is never dropped.
   always_comb begin
      for (int unsigned i = 0; i < COUNT; i++) begin
         inc_ext[i]  = stat_valid[i] ?
                       STAT_INC_WIDTH'(stat_inc[i*INC_WIDTH +: INC_WIDTH]) : '0;
         acc_sum[i]  = SUM_W'(acc[i]) + SUM_W'(inc_ext[i]);
         acc_next[i] = acc_sum[i][STAT_INC_WIDTH-1:0];
         if (emit && (ptr == PTR_W'(i)))
            acc_next[i] = inc_ext[i];
         else if (acc_sum[i] > SUM_W'(ACC_MAX))
            acc_next[i] = ACC_MAX;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '{default: '0};
      end else begin
         acc <= acc_next;
      end
   end

   // Output register, held stable while the beat is stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_axis_stat_tvalid <= 1'b0;
         m_axis_stat_tdata  <= '0;
         m_axis_stat_tid    <= '0;
      end else if (slot_free) begin
         m_axis_stat_tvalid <= emit;
         if (emit) begin
            m_axis_stat_tdata <= acc_cur;
            m_axis_stat_tid   <= ID_BASE + STAT_ID_WIDTH'(ptr);
         end
      end
   end

endmodule

// File: tb/tb_stats_collect.sv
// Testbench for stats_collect. Two instances: A (COUNT=4, UPDATE_PERIOD=16)
// and B (COUNT=8, UPDATE_PERIOD=1000, STAT_ID_BASE=250). Expected beats are
// queued per instance; a negedge monitor pops and compares on each handshake.
module tb_stats_collect;

   typedef struct {
      logic [7:0]  tid;
      logic [15:0] data;
   } beat_t;

   logic        clk;
   logic        rst;

   logic [31:0] a_inc;
   logic [3:0]  a_valid;
   logic [15:0] a_tdata;
   logic [7:0]  a_tid;
   logic        a_tvalid;
   logic        a_tready;

   logic [63:0] b_inc;
   logic [7:0]  b_valid;
   logic [15:0] b_tdata;
   logic [7:0]  b_tid;
   logic        b_tvalid;
   logic        b_tready;

   beat_t       q_a[$];
   beat_t       q_b[$];

   int          n_tests;
   int          n_fail;

   bit          prev_stall [2];
   logic [15:0] prev_data  [2];
   logic [7:0]  prev_tid   [2];
   bit          sum_mode   [2];
   int unsigned sum_total  [2];

   stats_collect #(
      .COUNT(4), .INC_WIDTH(8), .STAT_INC_WIDTH(16), .STAT_ID_WIDTH(8),
      .STAT_ID_BASE(0), .UPDATE_PERIOD(16)
   ) dut_a (
      .clk(clk), .rst(rst), .stat_inc(a_inc), .stat_valid(a_valid),
      .m_axis_stat_tdata(a_tdata), .m_axis_stat_tid(a_tid),
      .m_axis_stat_tvalid(a_tvalid), .m_axis_stat_tready(a_tready)
   );

   stats_collect #(
      .COUNT(8), .INC_WIDTH(8), .STAT_INC_WIDTH(16), .STAT_ID_WIDTH(8),
      .STAT_ID_BASE(250), .UPDATE_PERIOD(1000)
   ) dut_b (
      .clk(clk), .rst(rst), .stat_inc(b_inc), .stat_valid(b_valid),
      .m_axis_stat_tdata(b_tdata), .m_axis_stat_tid(b_tid),
      .m_axis_stat_tvalid(b_tvalid), .m_axis_stat_tready(b_tready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   task automatic check(input bit ok, input string name,
                        input int unsigned act, input int unsigned exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_a(input logic [7:0] tid, input logic [15:0] data);
      beat_t e;
      e.tid  = tid;
      e.data = data;
      q_a.push_back(e);
   endtask

   task automatic push_b(input logic [7:0] tid, input logic [15:0] data);
      beat_t e;
      e.tid  = tid;
      e.data = data;
      q_b.push_back(e);
   endtask

   task automatic mon(input int d, input logic v, input logic r,
                      input logic [15:0] dat, input logic [7:0] id);
      beat_t e;
      bit    empty;
      if (prev_stall[d]) begin
         check(v == 1'b1, "stall_tvalid", v, 1);
         check(dat == prev_data[d], "stall_tdata", dat, prev_data[d]);
         check(id == prev_tid[d], "stall_tid", id, prev_tid[d]);
      end
      if (v && r) begin
         n_tests++;
         if (dat == 16'd0) begin
            n_fail++;
            $display("FAIL nonzero_tdata dut%0d: got 0 required nonzero", d);
         end
         empty = (d == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
         if (sum_mode[d]) begin
            check(id == 8'd1, "sum_tid", id, 1);
            sum_total[d] += dat;
         end else if (empty) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat dut%0d: got tid %0d tdata %0d required none",
                     d, id, dat);
         end else begin
            if (d == 0) e = q_a.pop_front();
            else        e = q_b.pop_front();
            check(id == e.tid, "beat_tid", id, e.tid);
            check(dat == e.data, "beat_tdata", dat, e.data);
         end
      end
      prev_stall[d] = v && !r;
      prev_data[d]  = dat;
      prev_tid[d]   = id;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_stall[0] = 1'b0;
         prev_stall[1] = 1'b0;
      end else begin
         mon(0, a_tvalid, a_tready, a_tdata, a_tid);
         mon(1, b_tvalid, b_tready, b_tdata, b_tid);
      end
   end

   // Leaves the bench 1 time unit after the first active edge out of reset.
   task automatic do_reset();
      rst = 1'b1;
      q_a.delete();
      q_b.delete();
      sum_mode[0] = 1'b0;
      sum_mode[1] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit found;
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      a_inc     = '0;
      a_valid   = '0;
      a_tready  = 1'b0;
      b_inc     = '0;
      b_valid   = '0;
      b_tready  = 1'b0;
      sum_total[0] = 0;
      sum_total[1] = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check(a_tvalid == 1'b0, "rst_a_tvalid", a_tvalid, 0);
      check(a_tdata == 16'd0, "rst_a_tdata", a_tdata, 0);
      check(a_tid == 8'd0, "rst_a_tid", a_tid, 0);
      check(b_tvalid == 1'b0, "rst_b_tvalid", b_tvalid, 0);
      check(b_tdata == 16'd0, "rst_b_tdata", b_tdata, 0);
      check(b_tid == 8'd0, "rst_b_tid", b_tid, 0);

      // Single sweep: channel 2 gets 5 for 3 cycles -> one beat of 15
      do_reset();
      a_tready = 1'b1;
      b_tready = 1'b1;
      push_a(8'd2, 16'd15);
      a_valid = 4'b0100;
      a_inc   = 32'h0005_0000;
      repeat (3) @(posedge clk);
      #1;
      a_valid = '0;
      a_inc   = '0;
      repeat (18) @(posedge clk);
      #1;
      check(q_a.size() == 0, "t1_beat_in_window", q_a.size(), 0);
      repeat (40) @(posedge clk);
      #1;

      // Back-pressure: channel 1 gets 3 for 60 cycles, tready low for 40
      do_reset();
      a_tready     = 1'b0;
      sum_mode[0]  = 1'b1;
      sum_total[0] = 0;
      a_valid = 4'b0010;
      a_inc   = 32'h0000_0300;
      repeat (40) @(posedge clk);
      #1;
      a_tready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      a_valid = '0;
      a_inc   = '0;
      repeat (80) @(posedge clk);
      #1;
      check(sum_total[0] == 180, "t2_sum_tid1", sum_total[0], 180);
      sum_mode[0] = 1'b0;

      // Urgent drain on B channel 0 (ptr phase gives 255*135), residue and
      // a single channel-7 increment (tid 250+7 wraps to 1) in the timer sweep
      do_reset();
      b_tready = 1'b1;
      push_b(8'd250, 16'd34425);
      push_b(8'd250, 16'd1275);
      push_b(8'd1, 16'd9);
      b_valid = 8'b1000_0001;
      b_inc   = 64'h0900_0000_0000_00FF;
      @(posedge clk);
      #1;
      b_valid = 8'b0000_0001;
      b_inc   = 64'h0000_0000_0000_00FF;
      repeat (139) @(posedge clk);
      #1;
      b_valid = '0;
      b_inc   = '0;
      repeat (4) @(posedge clk);
      #1;
      check(q_b.size() == 2, "t3_urgent_before_sweep", q_b.size(), 2);
      repeat (900) @(posedge clk);
      #1;
      check(q_b.size() == 0, "t3_sweep_drain", q_b.size(), 0);

      // Saturation: tready low, channel 3 gets 255 for 400 cycles
      do_reset();
      b_tready = 1'b0;
      push_b(8'd253, 16'd33150);
      push_b(8'd253, 16'hFFFF);
      b_valid = 8'b0000_1000;
      b_inc   = 64'h0000_0000_FF00_0000;
      repeat (400) @(posedge clk);
      #1;
      b_valid = '0;
      b_inc   = '0;
      repeat (5) @(posedge clk);
      #1;
      b_tready = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check(q_b.size() == 0, "t4_saturated_drain", q_b.size(), 0);

      // Asynchronous reset while a beat is held
      do_reset();
      a_tready = 1'b0;
      a_valid  = 4'b0001;
      a_inc    = 32'h0000_0001;
      found    = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(posedge clk);
         #1;
         if (a_tvalid) found = 1'b1;
      end
      check(found, "t5_tvalid_seen", found, 1);
      a_valid = '0;
      a_inc   = '0;
      #2;
      rst = 1'b1;
      #1;
      check(a_tvalid == 1'b0, "t5_async_tvalid", a_tvalid, 0);
      check(a_tdata == 16'd0, "t5_async_tdata", a_tdata, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      a_tready = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check(a_tvalid == 1'b0, "t5_no_beats", a_tvalid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stats_collect.md
Name: stats_collect

Overview:
- Upstream feeder for the statistics counter block.
- Gathers per-cycle event increments from COUNT local sources into narrow local accumulators.
- Periodically, or on near-overflow, serialises non-zero accumulator values as (tdata = increment, tid = counter ID) beats on an AXI-stream increment output.
- Lets many high-rate event sources share one single-ported counter memory without losing counts.

Parameters:
- COUNT, 8: number of input channels (1..256).
- INC_WIDTH, 8: per-cycle increment width per channel.
- STAT_INC_WIDTH, 16: accumulator and output tdata width; must be > INC_WIDTH.
- STAT_ID_WIDTH, 8: output tid width.
- STAT_ID_BASE, 0: tid emitted for channel 0; channel i emits STAT_ID_BASE+i (mod 2^STAT_ID_WIDTH).
- UPDATE_PERIOD, 1024: cycles between sweep starts; 0 means sweep continuously.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- stat_inc  in  COUNT*INC_WIDTH  per-channel increment; channel i at [i*INC_WIDTH +: INC_WIDTH]
- stat_valid  in  COUNT  qualifies stat_inc per channel; no back-pressure
- m_axis_stat_tdata  out  STAT_INC_WIDTH  accumulated increment
- m_axis_stat_tid  out  STAT_ID_WIDTH  counter ID
- m_axis_stat_tvalid  out  1  beat valid
- m_axis_stat_tready  in  1  downstream ready

Behaviour:
- Single clock domain. All state uses asynchronous active-high reset.
- Reset values:
  - acc[i] = 0 for all i.
  - tvalid = 0; tdata = 0; tid = 0.
  - state = IDLE; ptr = 0; timer = UPDATE_PERIOD; sweep_pending = 0.
- Accumulation, every cycle, per channel: acc_next[i] = sat(acc[i] + (stat_valid[i] ? stat_inc[i] : 0)).
  - sat clamps to 2^STAT_INC_WIDTH-1. Clamping is the only documented count loss.
- Output slot free = !tvalid || tready. The output register holds its value while tvalid && !tready (AXI-stream stable).
- Emission of channel p:
  - Loads tdata = acc[p] (value before this cycle's add), tid = STAT_ID_BASE+p, tvalid = 1.
  - Sets acc_next[p] = this cycle's increment for p, so simultaneous increment and emission loses nothing.
  - At most one emission per cycle.
- Timer:
  - Decrements every cycle while non-zero.
  - At 0: sets sweep_pending and reloads to UPDATE_PERIOD-1.
  - UPDATE_PERIOD=0 keeps sweep_pending permanently 1.
- State IDLE:
  - ptr advances (wraps COUNT-1 -> 0) every cycle.
  - If slot free and acc[ptr] MSB set (urgent, at least half full), emit ptr.
  - If sweep_pending: clear it, set ptr = 0, go to SWEEP.
- State SWEEP:
  - At ptr, if acc[ptr] == 0, advance ptr.
  - Else if slot free, emit ptr and advance.
  - Else stall ptr.
  - After handling ptr = COUNT-1, go to IDLE and set ptr = 0.
  - A timer expiry during a sweep only sets sweep_pending, so the next sweep follows immediately.
- Latency: an increment seen at cycle t is in acc at t+1. Earliest output beat is at t+2 (sweep visits that channel with slot free).
- Worst-case drain: a full sweep takes at least COUNT cycles and no more than COUNT + stall cycles.
- Reset mid-operation: in-flight beat and all accumulated counts are discarded. The downstream counter block zeroes its own memory on its own reset.
- A beat with tdata = 0 is never emitted.

Decomposition:
- Shared package: state encodings (STATE_IDLE, STATE_SWEEP), saturating-add width rule, STAT_ID offset computation.
- No sub-module. The accumulator array and scan/emit FSM stay in one module; acc is a flip-flop array, since all channels update in parallel.

Test Plan:
- UPDATE_PERIOD=16, COUNT=4. Channel 2 gets stat_inc=5 for 3 cycles, tready=1 -> exactly one beat, tid=2, tdata=15, within 16+4 cycles. No beats for channels 0, 1, 3.
- Channel 1 gets stat_inc=3 every cycle; tready held 0 for 40 cycles, then 1 -> beats never change while stalled. Sum of all tdata for tid=1 equals 3 * number of valid cycles, so no count is lost across emission cycles.
- UPDATE_PERIOD=1000, channel 0 gets inc=255 every cycle, STAT_INC_WIDTH=16 -> urgent beat issued once acc >= 0x8000, before any timer sweep. No saturation occurs.
- tready=0 forever, channel 3 gets inc=255 every cycle -> acc[3] clamps at 0xFFFF. Releasing tready produces beats with tdata=0xFFFF, and no wrap to a small value occurs.
- Assert rst asynchronously, mid-cycle, while tvalid=1 -> tvalid=0 immediately, before the next clk edge. No beats follow until new increments arrive.
- STAT_ID_BASE=250, COUNT=8, STAT_ID_WIDTH=8, one increment on channel 7 -> tid = 1 (wraps mod 256).
